// File: rtl/sync_debounce.sv
// sync_debounce: S-stage synchronizer plus per-channel debounce filter.
// Ports: c clock; rst sync active-high reset; d async inputs (W);
//        q debounced level (W); rise/fall edge pulses (W);
//        chg OR of all pulses. Every output is a flop.
module sync_debounce #(
  parameter int              W       = 1,
  parameter int              S       = 2,
  parameter int              DB      = 4,
  parameter logic [W-1:0]    RST_VAL = {W{1'b0}}
) (
  input  logic         c,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall,
  output logic         chg
);

  localparam int CW = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DB - 1);

  // Keep the chain as discrete flops: an SRL would wreck the
  // metastability margin between stages.
  (* shreg_extract = "no", srl_style = "register" *)
  logic [S-1:0][W-1:0] sync_q = {S{RST_VAL}};
  logic [S-1:0][W-1:0] sync_d;

  logic [W-1:0][CW-1:0] cnt_q = '0;
  logic [W-1:0][CW-1:0] cnt_d;

  logic [W-1:0] q_q    = RST_VAL;
  logic [W-1:0] rise_q = '0;
  logic [W-1:0] fall_q = '0;
  logic         chg_q  = 1'b0;

  logic [W-1:0] q_d;
  logic [W-1:0] rise_d;
  logic [W-1:0] fall_d;
  logic         chg_d;
  logic [W-1:0] y;

  always_comb begin
    sync_d = {sync_q[S-2:0], d};
    y      = sync_q[S-1];
    cnt_d  = cnt_q;
    q_d    = q_q;
    for (int i = 0; i < W; i++) begin
      if (y[i] == q_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CMAX) begin
        q_d[i]   = y[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
    chg_d  = |(rise_d | fall_d);
  end

  always_ff @(posedge c) begin
    if (rst) begin
      sync_q <= {S{RST_VAL}};
      cnt_q  <= '0;
      q_q    <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign chg  = chg_q;

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: directed + random checks of sync_debounce.
// Two instances: W4/S2/DB4/RST0 and W2/S3/DB1/RST2'b10.
module tb_sync_debounce;

  logic       c = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d0 = '0;
  logic [1:0] d1 = '0;
  logic [3:0] q0, r0, f0;
  logic [1:0] q1, r1, f1;
  logic       c0, c1;

  int checks = 0;
  int errors = 0;

  always #5 c = ~c;

  sync_debounce #(
    .W(4), .S(2), .DB(4), .RST_VAL(4'b0000)
  ) dut0 (
    .c(c), .rst(rst), .d(d0),
    .q(q0), .rise(r0), .fall(f0), .chg(c0)
  );

  sync_debounce #(
    .W(2), .S(3), .DB(1), .RST_VAL(2'b10)
  ) dut1 (
    .c(c), .rst(rst), .d(d1),
    .q(q1), .rise(r1), .fall(f1), .chg(c1)
  );

  // Reference: q flips once the last DB candidate samples,
  // all taken after the previous flip, disagree with q.
  // Candidate at edge t is the d sampled at edge t-S.
  int         pw  [2] = '{4, 2};
  int         ps  [2] = '{2, 3};
  int         pdb [2] = '{4, 1};
  logic [3:0] prv [2] = '{4'h0, 4'h2};
  logic [3:0] smp [2][8192];
  int         nt  [2];
  int         lf  [2][4];
  logic [3:0] mq  [2];
  logic [3:0] mr  [2];
  logic [3:0] mf  [2];
  logic       mc  [2];

  task automatic mstep(input int k, input logic [3:0] din,
                       input logic r);
    logic yv;
    bit   flip;
    int   tt;
    mr[k] = '0;
    mf[k] = '0;
    mc[k] = 1'b0;
    if (r) begin
      nt[k] = 0;
      mq[k] = prv[k];
      for (int i = 0; i < 4; i++) lf[k][i] = 0;
      return;
    end
    nt[k] = nt[k] + 1;
    smp[k][nt[k]] = din;
    for (int i = 0; i < pw[k]; i++) begin
      flip = 1'b1;
      for (int j = 0; j < pdb[k]; j++) begin
        tt = nt[k] - j;
        if (tt <= lf[k][i]) begin
          flip = 1'b0;
        end else begin
          if (tt - ps[k] >= 1) yv = smp[k][tt-ps[k]][i];
          else yv = prv[k][i];
          if (yv == mq[k][i]) flip = 1'b0;
        end
      end
      if (flip) begin
        mq[k][i] = ~mq[k][i];
        lf[k][i] = nt[k];
        if (mq[k][i]) mr[k][i] = 1'b1;
        else mf[k][i] = 1'b1;
      end
    end
    mc[k] = |(mr[k] | mf[k]);
  endtask

  task automatic tick();
    @(posedge c);
    #1;
    mstep(0, d0, rst);
    mstep(1, {2'b00, d1}, rst);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d0  = 4'hF;
    d1  = 2'b01;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if ({q0, r0, f0, c0} !== 13'b0 || q1 !== 2'b10) begin
        errors++;
        $display("FAIL reset_hold q0=%h r0=%h f0=%h chg=%b q1=%b exp 0/0/0/0/10",
                 q0, r0, f0, c0, q1);
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (q0 !== (n >= 6 ? 4'hF : 4'h0) ||
          r0 !== (n == 6 ? 4'hF : 4'h0) ||
          f0 !== 4'h0 || c0 !== (n == 6)) begin
        errors++;
        $display("FAIL reset_release n=%0d q=%h r=%h f=%h chg=%b",
                 n, q0, r0, f0, c0);
      end
    end
  endtask

  task automatic test_latency();
    rst = 1'b1;
    d0  = 4'h0;
    d1  = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    d0  = 4'b0001;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++;
      if (q0[0] !== (n >= 6) || r0[0] !== (n == 6) ||
          c0 !== (n == 6) || f0 !== 4'h0) begin
        errors++;
        $display("FAIL latency n=%0d q=%h r=%h f=%h chg=%b exp q0=%0d",
                 n, q0, r0, f0, c0, n >= 6);
      end
    end
  endtask

  task automatic test_glitch();
    for (int n = 1; n <= 15; n++) begin
      d0[1] = (n <= 3);
      tick();
      checks++;
      if (q0[1] !== 1'b0 || r0[1] !== 1'b0 ||
          f0[1] !== 1'b0 || c0 !== 1'b0) begin
        errors++;
        $display("FAIL glitch3 n=%0d q=%h r=%h f=%h chg=%b exp no change",
                 n, q0, r0, f0, c0);
      end
    end
    for (int n = 1; n <= 15; n++) begin
      d0[1] = (n <= 4);
      tick();
      checks++;
      if (q0[1] !== (n >= 6 && n <= 9) || r0[1] !== (n == 6) ||
          f0[1] !== (n == 10) || c0 !== (n == 6 || n == 10)) begin
        errors++;
        $display("FAIL glitch4 n=%0d q=%h r=%h f=%h chg=%b",
                 n, q0, r0, f0, c0);
      end
    end
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    d0  = 4'b1000;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    checks++;
    if (q0 !== 4'b1000) begin
      errors++;
      $display("FAIL simul_setup q=%b exp 1000", q0);
    end
    d0 = 4'b0100;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (q0 !== (n >= 6 ? 4'b0100 : 4'b1000) ||
          r0 !== (n == 6 ? 4'b0100 : 4'b0000) ||
          f0 !== (n == 6 ? 4'b1000 : 4'b0000) ||
          c0 !== (n == 6)) begin
        errors++;
        $display("FAIL simul n=%0d q=%b r=%b f=%b chg=%b",
                 n, q0, r0, f0, c0);
      end
    end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1;
    d0  = 4'h0;
    tick();
    rst = 1'b0;
    d0  = 4'b0001;
    for (int n = 1; n <= 5; n++) begin
      rst = (n == 5);
      tick();
      checks++;
      if (q0 !== 4'h0 || r0 !== 4'h0 || f0 !== 4'h0 || c0 !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_pre n=%0d q=%h r=%h chg=%b exp 0",
                 n, q0, r0, c0);
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (q0[0] !== (n >= 6) || r0[0] !== (n == 6) || f0 !== 4'h0) begin
        errors++;
        $display("FAIL rst_mid_post n=%0d q=%h r=%h f=%h",
                 n, q0, r0, f0);
      end
    end
  endtask

  task automatic test_bounce();
    int nr;
    int nf;
    nr  = 0;
    nf  = 0;
    rst = 1'b1;
    d0  = 4'h0;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      d0[2] = ((n % 4) < 2);
      tick();
      nr += r0[2];
      nf += f0[2];
      checks++;
      if (q0[2] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_hold n=%0d q=%h exp q[2]=0", n, q0);
      end
    end
    d0[2] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      nr += r0[2];
      nf += f0[2];
      checks++;
      if (q0[2] !== (n >= 6)) begin
        errors++;
        $display("FAIL bounce_settle n=%0d q=%h exp q[2]=%0d",
                 n, q0, n >= 6);
      end
    end
    checks++;
    if (nr != 1 || nf != 0) begin
      errors++;
      $display("FAIL bounce_pulses rise=%0d fall=%0d exp 1/0", nr, nf);
    end
  endtask

  task automatic test_random();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) d0[i] = ~d0[i];
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 2) == 0) d1[i] = ~d1[i];
      tick();
      checks++;
      if (q0 !== mq[0] || r0 !== mr[0] ||
          f0 !== mf[0] || c0 !== mc[0]) begin
        errors++;
        $display("FAIL rand_db4 n=%0d q=%h/%h r=%h/%h f=%h/%h chg=%b/%b",
                 n, q0, mq[0], r0, mr[0], f0, mf[0], c0, mc[0]);
      end
      checks++;
      if (q1 !== mq[1][1:0] || r1 !== mr[1][1:0] ||
          f1 !== mf[1][1:0] || c1 !== mc[1]) begin
        errors++;
        $display("FAIL rand_db1 n=%0d q=%b/%b r=%b/%b f=%b/%b chg=%b/%b",
                 n, q1, mq[1][1:0], r1, mr[1][1:0],
                 f1, mf[1][1:0], c1, mc[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_simultaneous();
    test_rst_mid();
    test_bounce();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
